// File: rtl/div_share_arbiter_if.sv
// rtl/div_share_arbiter_if.sv - requester, divider and response signals of the shared divider arbiter
interface div_share_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   i_REQ;
    logic [NUM_REQ*8-1:0] i_DIVIDEND;
    logic [NUM_REQ*8-1:0] i_DIVISOR;
    logic [NUM_REQ-1:0]   o_GNT;
    logic                 o_DIV_START;
    logic [7:0]           o_DIV_DIVIDEND;
    logic [7:0]           o_DIV_DIVISOR;
    logic [13:0]          i_DIV_QUOTIENT;
    logic                 o_RESP_VALID;
    logic [ID_W-1:0]      o_RESP_ID;
    logic [13:0]          o_QUOTIENT;
    logic                 o_DIVZERO;
    logic                 o_BUSY;

    modport slave (
        input  i_REQ, i_DIVIDEND, i_DIVISOR, i_DIV_QUOTIENT,
        output o_GNT, o_DIV_START, o_DIV_DIVIDEND, o_DIV_DIVISOR,
        output o_RESP_VALID, o_RESP_ID, o_QUOTIENT, o_DIVZERO, o_BUSY
    );

    modport master (
        output i_REQ, i_DIVIDEND, i_DIVISOR, i_DIV_QUOTIENT,
        input  o_GNT, o_DIV_START, o_DIV_DIVIDEND, o_DIV_DIVISOR,
        input  o_RESP_VALID, o_RESP_ID, o_QUOTIENT, o_DIVZERO, o_BUSY
    );
endinterface

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin sharing of one 8-bit LUT divider between pixel requesters
module div_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DIV_LAT = 2
) (
    input logic                i_CLK,
    input logic                i_RSTn,
    div_share_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]              ptr;
    logic                         gnt_any;
    logic [ID_W-1:0]              gnt_id;
    logic [7:0]                   sel_dividend;
    logic [7:0]                   sel_divisor;
    // Stage s holds the operation accepted s edges ago; stage DIV_LAT meets the divider result.
    logic [DIV_LAT:0]             tag_v;
    logic [DIV_LAT:0]             tag_z;
    logic [DIV_LAT:0][ID_W-1:0]   tag_id;

    // First requester at or above the pointer (wrapping) wins; nothing is granted while in reset.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        gnt_any      = 1'b0;
        gnt_id       = '0;
        sum          = '0;
        idx          = '0;
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!gnt_any && bus.i_REQ[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
        if (!i_RSTn) begin
            gnt_any = 1'b0;
            gnt_id  = '0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                sel_dividend = bus.i_DIVIDEND[k*8 +: 8];
                sel_divisor  = bus.i_DIVISOR[k*8 +: 8];
            end
        end
    end

    assign bus.o_GNT  = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
    assign bus.o_BUSY = (|tag_v) | bus.o_DIV_START;

    // Issue to the divider, advance the tag pipeline and return tagged results.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            ptr                <= '0;
            tag_v              <= '0;
            tag_z              <= '0;
            tag_id             <= '0;
            bus.o_DIV_START    <= 1'b0;
            bus.o_DIV_DIVIDEND <= '0;
            bus.o_DIV_DIVISOR  <= '0;
            bus.o_RESP_VALID   <= 1'b0;
            bus.o_RESP_ID      <= '0;
            bus.o_QUOTIENT     <= '0;
            bus.o_DIVZERO      <= 1'b0;
        end else begin
            tag_v  <= {tag_v[DIV_LAT-1:0], gnt_any};
            tag_z  <= {tag_z[DIV_LAT-1:0], (sel_divisor == 8'd0)};
            tag_id <= {tag_id[DIV_LAT-1:0], gnt_id};

            bus.o_DIV_START <= gnt_any;
            if (gnt_any) begin
                bus.o_DIV_DIVIDEND <= sel_dividend;
                bus.o_DIV_DIVISOR  <= sel_divisor;
                ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
            end

            bus.o_RESP_VALID <= tag_v[DIV_LAT];
            if (tag_v[DIV_LAT]) begin
                bus.o_RESP_ID  <= tag_id[DIV_LAT];
                bus.o_DIVZERO  <= tag_z[DIV_LAT];
                bus.o_QUOTIENT <= tag_z[DIV_LAT] ? 14'h3FFF : bus.i_DIV_QUOTIENT;
            end
        end
    end
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - randomized scoreboard bench for the shared divider arbiter
module tb_div_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DIV_LAT = 2;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  id;
        logic [13:0] q;
        logic        z;
    } resp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    resp_t      obs_q[$];
    resp_t      exp_q[$];
    int         m_ptr = 0;
    logic [3:0] last_gnt;
    int         last_k;

    div_share_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    div_share_arbiter #(.NUM_REQ(NUM_REQ), .DIV_LAT(DIV_LAT)) dut (
        .i_CLK (clk),
        .i_RSTn(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: samples start, result ready DIV_LAT edges later; returns 0 for b=0, junk when idle.
    logic [13:0] dpipe [DIV_LAT];
    always @(posedge clk) begin
        if (bus.o_DIV_START === 1'b1)
            dpipe[0] <= (bus.o_DIV_DIVISOR == 8'd0) ? 14'h0000
                      : 14'((int'(bus.o_DIV_DIVIDEND) * 64) / int'(bus.o_DIV_DIVISOR));
        else
            dpipe[0] <= 14'($urandom);
        for (int s = 1; s < DIV_LAT; s++) dpipe[s] <= dpipe[s-1];
    end
    assign bus.i_DIV_QUOTIENT = dpipe[DIV_LAT-1];

    // Every response strobe is logged with the cycle it was seen in.
    always @(negedge clk)
        if (bus.o_RESP_VALID !== 1'b0)
            obs_q.push_back('{cyc: 32'(cyc), id: bus.o_RESP_ID, q: bus.o_QUOTIENT, z: bus.o_DIVZERO});

    function automatic logic [7:0] pick_a();
        case ($urandom_range(0, 5))
            0:       return 8'd0;
            1:       return 8'd255;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic logic [7:0] pick_b();
        case ($urandom_range(0, 7))
            0:       return 8'd0;
            1:       return 8'd1;
            2:       return 8'd255;
            default: return 8'($urandom_range(1, 255));
        endcase
    endfunction

    // One clock: drive requests, sample the grant at the falling edge, predict grant and response.
    task automatic clk_step(input logic [3:0] req, input logic [31:0] a_pk, input logic [31:0] b_pk);
        int k;
        int a;
        int b;
        bus.i_REQ      = req;
        bus.i_DIVIDEND = a_pk;
        bus.i_DIVISOR  = b_pk;
        @(negedge clk);
        last_gnt = bus.o_GNT;
        k = -1;
        for (int i = 0; i < NUM_REQ; i++)
            if (k < 0 && req[(m_ptr + i) % NUM_REQ]) k = (m_ptr + i) % NUM_REQ;
        last_k = k;
        if (k >= 0) begin
            a = int'(a_pk[k*8 +: 8]);
            b = int'(b_pk[k*8 +: 8]);
            exp_q.push_back('{cyc: 32'(cyc + DIV_LAT + 2), id: 2'(k),
                              q: (b == 0) ? 14'h3FFF : 14'((a * 64) / b), z: (b == 0)});
            m_ptr = (k + 1) % NUM_REQ;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.i_REQ = '0;
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_ptr = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        bus.i_REQ      = 4'hF;
        bus.i_DIVIDEND = $urandom;
        bus.i_DIVISOR  = $urandom;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.o_GNT !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b, expected 0000", bus.o_GNT); end
        n_cmp++; if (bus.o_DIV_START !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b, expected 0", bus.o_DIV_START); end
        n_cmp++; if (bus.o_DIV_DIVIDEND !== 8'd0 || bus.o_DIV_DIVISOR !== 8'd0) begin n_bad++; $display("FAIL reset_operands: got %h/%h, expected 00/00", bus.o_DIV_DIVIDEND, bus.o_DIV_DIVISOR); end
        n_cmp++; if (bus.o_RESP_VALID !== 1'b0 || bus.o_BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_valid_busy: got %b%b, expected 00", bus.o_RESP_VALID, bus.o_BUSY); end
        n_cmp++; if (bus.o_QUOTIENT !== 14'd0 || bus.o_RESP_ID !== 2'd0 || bus.o_DIVZERO !== 1'b0) begin n_bad++; $display("FAIL reset_resp: got q=%h id=%0d z=%b, expected 0", bus.o_QUOTIENT, bus.o_RESP_ID, bus.o_DIVZERO); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.o_GNT !== 4'b0001) begin n_bad++; $display("FAIL reset_ptr: got gnt %b, expected 0001", bus.o_GNT); end
        bus.i_REQ = '0;
        @(posedge clk);
        #1;
        m_ptr = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_single();
        exp_q.delete();
        obs_q.delete();
        clk_step(4'b0001, {24'h0, 8'd50}, {24'h0, 8'd5});
        n_cmp++; if (last_gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt: got %b, expected 0001", last_gnt); end
        n_cmp++; if (bus.o_DIV_START !== 1'b1 || bus.o_DIV_DIVIDEND !== 8'd50 || bus.o_DIV_DIVISOR !== 8'd5) begin
            n_bad++; $display("FAIL single_issue: got start=%b %0d/%0d, expected 1 50/5", bus.o_DIV_START, bus.o_DIV_DIVIDEND, bus.o_DIV_DIVISOR); end
        repeat (5) clk_step(4'b0000, 32'h0, 32'h0);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL single_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL single_resp[%0d]: got cyc=%0d id=%0d q=%h z=%b, expected cyc=%0d id=%0d q=%h z=%b",
                i, obs_q[i].cyc, obs_q[i].id, obs_q[i].q, obs_q[i].z, exp_q[i].cyc, exp_q[i].id, exp_q[i].q, exp_q[i].z); end
        end
        n_cmp++; if (bus.o_QUOTIENT !== 14'h280 || bus.o_BUSY !== 1'b0 || bus.o_RESP_VALID !== 1'b0) begin
            n_bad++; $display("FAIL single_after: got q=%h busy=%b valid=%b, expected 280 0 0", bus.o_QUOTIENT, bus.o_BUSY, bus.o_RESP_VALID); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_pk;
        logic [31:0] b_pk;
        logic [3:0]  exp_g;
        apply_reset();
        a_pk = {pick_a(), pick_a(), 8'd50, 8'd255};
        b_pk = {pick_b(), pick_b(), 8'd3, 8'd1};
        for (int i = 0; i < 8; i++) begin
            clk_step(4'hF, a_pk, b_pk);
            exp_g = 4'(1 << (i % 4));
            n_cmp++; if (last_gnt !== exp_g) begin n_bad++; $display("FAIL b2b_gnt[%0d]: got %b, expected %b", i, last_gnt, exp_g); end
            n_cmp++; if (bus.o_DIV_START !== 1'b1) begin n_bad++; $display("FAIL b2b_start[%0d]: got %b, expected 1", i, bus.o_DIV_START); end
        end
        repeat (6) clk_step(4'b0000, 32'h0, 32'h0);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_resp[%0d]: got cyc=%0d id=%0d q=%h z=%b, expected cyc=%0d id=%0d q=%h z=%b",
                i, obs_q[i].cyc, obs_q[i].id, obs_q[i].q, obs_q[i].z, exp_q[i].cyc, exp_q[i].id, exp_q[i].q, exp_q[i].z); end
        end
        if (obs_q.size() >= 2) begin
            n_cmp++; if (obs_q[0].q !== 14'h3FC0 || obs_q[1].q !== 14'd1066) begin
                n_bad++; $display("FAIL b2b_values: got %h,%h, expected 3fc0,042a", obs_q[0].q, obs_q[1].q); end
        end
    endtask

    task automatic test_divzero();
        exp_q.delete();
        obs_q.delete();
        clk_step(4'b0100, {8'd0, 8'd50, 16'h0}, 32'h0);
        n_cmp++; if (last_gnt !== 4'b0100) begin n_bad++; $display("FAIL divzero_gnt: got %b, expected 0100", last_gnt); end
        repeat (5) clk_step(4'b0000, 32'h0, 32'h0);
        n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL divzero_count: got %0d responses, expected 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            n_cmp++; if (obs_q[0] !== exp_q[0] || obs_q[0].id !== 2'd2 || obs_q[0].q !== 14'h3FFF || obs_q[0].z !== 1'b1) begin
                n_bad++; $display("FAIL divzero_resp: got cyc=%0d id=%0d q=%h z=%b, expected cyc=%0d id=2 q=3fff z=1",
                    obs_q[0].cyc, obs_q[0].id, obs_q[0].q, obs_q[0].z, exp_q[0].cyc); end
        end
    endtask

    task automatic test_fairness();
        logic [3:0]  fx_req [6] = '{4'b1000, 4'b0010, 4'b0000, 4'b1000, 4'b1001, 4'b1000};
        logic [3:0]  fx_gnt [6] = '{4'b1000, 4'b0010, 4'b0000, 4'b1000, 4'b0001, 4'b1000};
        logic [3:0]  pend;
        logic [31:0] a_pk;
        logic [31:0] b_pk;
        logic [3:0]  exp_g;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            clk_step(fx_req[i], $urandom, $urandom);
            n_cmp++; if (last_gnt !== fx_gnt[i]) begin n_bad++; $display("FAIL fair_fixed[%0d]: got %b, expected %b", i, last_gnt, fx_gnt[i]); end
        end
        pend = '0;
        a_pk = '0;
        b_pk = '0;
        for (int c = 0; c < 80; c++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    a_pk[r*8 +: 8] = pick_a();
                    b_pk[r*8 +: 8] = pick_b();
                end else if (pend[r] && $urandom_range(0, 15) == 0) begin
                    pend[r] = 1'b0;
                end
            end
            clk_step(pend, a_pk, b_pk);
            exp_g = (last_k >= 0) ? 4'(1 << last_k) : 4'b0000;
            n_cmp++; if (last_gnt !== exp_g) begin n_bad++; $display("FAIL fair_rand[%0d]: got %b, expected %b (req %b)", c, last_gnt, exp_g, pend); end
            if (last_k >= 0) pend[last_k] = 1'b0;
        end
        repeat (6) clk_step(4'b0000, 32'h0, 32'h0);
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        clk_step(4'b0001, $urandom, {24'h0, 8'd7});
        clk_step(4'b0010, $urandom, {16'h0, 8'd9, 8'd0});
        clk_step(4'b0000, 32'h0, 32'h0);
        bus.i_REQ = 4'hF;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.o_DIV_START !== 1'b0 || bus.o_BUSY !== 1'b0 || bus.o_RESP_VALID !== 1'b0 || bus.o_GNT !== 4'b0000) begin
            n_bad++; $display("FAIL midrst_outputs: got start=%b busy=%b valid=%b gnt=%b, expected 0 0 0 0000",
                bus.o_DIV_START, bus.o_BUSY, bus.o_RESP_VALID, bus.o_GNT); end
        n_cmp++; if (bus.o_DIV_DIVIDEND !== 8'd0 || bus.o_DIV_DIVISOR !== 8'd0) begin
            n_bad++; $display("FAIL midrst_operands: got %h/%h, expected 00/00", bus.o_DIV_DIVIDEND, bus.o_DIV_DIVISOR); end
        #6;
        rst_n = 1'b1;
        bus.i_REQ = '0;
        @(posedge clk);
        #1;
        m_ptr = 0;
        exp_q.delete();
        repeat (6) clk_step(4'b0000, 32'h0, 32'h0);
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL midrst_noresp: got %0d responses, expected 0", obs_q.size()); end
        clk_step(4'b1010, $urandom, {8'd1, 8'd1, 8'd1, 8'd1});
        n_cmp++; if (last_gnt !== 4'b0010) begin n_bad++; $display("FAIL midrst_ptr: got %b, expected 0010", last_gnt); end
        repeat (5) clk_step(4'b0000, 32'h0, 32'h0);
    endtask

    task automatic test_sweep();
        logic [3:0]  pend;
        logic [31:0] a_pk;
        logic [31:0] b_pk;
        logic [3:0]  exp_g;
        int          granted;
        apply_reset();
        pend = '0;
        a_pk = '0;
        b_pk = '0;
        granted = 0;
        for (int c = 0; c < 4000 && granted < 1500; c++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!pend[r] && $urandom_range(0, 3) != 0) begin
                    pend[r] = 1'b1;
                    a_pk[r*8 +: 8] = pick_a();
                    b_pk[r*8 +: 8] = pick_b();
                end
            end
            clk_step(pend, a_pk, b_pk);
            exp_g = (last_k >= 0) ? 4'(1 << last_k) : 4'b0000;
            n_cmp++; if (last_gnt !== exp_g) begin n_bad++; $display("FAIL sweep_gnt[%0d]: got %b, expected %b", c, last_gnt, exp_g); end
            if (last_k >= 0) begin
                pend[last_k] = 1'b0;
                granted++;
            end
        end
        repeat (6) clk_step(4'b0000, 32'h0, 32'h0);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL sweep_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL sweep_resp[%0d]: got cyc=%0d id=%0d q=%h z=%b, expected cyc=%0d id=%0d q=%h z=%b",
                i, obs_q[i].cyc, obs_q[i].id, obs_q[i].q, obs_q[i].z, exp_q[i].cyc, exp_q[i].id, exp_q[i].q, exp_q[i].z); end
        end
    endtask

    initial begin
        bus.i_REQ      = '0;
        bus.i_DIVIDEND = '0;
        bus.i_DIVISOR  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_divzero();
        test_fairness();
        test_reset_midflight();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
